// File: rtl/video_bus_pkg.sv
// Shared types and constants for the tile/palette board CPU-side bus.
package video_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    READ    = 3'd2,
    SEND_LO = 3'd3,
    SEND_HI = 3'd4,
    DONE    = 3'd5
  } rb_state_e;

  localparam logic [1:0] BYTE_SEL_WORD = 2'b11;

  // A[15] selects tile layer B inside the CHARA window; palette decode is board-internal.
  localparam int unsigned CHARA_LAYER_B_BIT = 15;

  function automatic logic chara_is_layer_b(input logic [15:0] addr);
    return addr[CHARA_LAYER_B_BIT];
  endfunction

endpackage

// File: rtl/board_b_d_readback_if.sv
// Board memory bus plus outgoing byte stream, grouped for the readback initiator.
interface board_b_d_readback_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] A;
  logic [1:0]        BYTE_SEL;
  logic              MRD;
  logic              CHARA;
  logic [15:0]       DIN;
  logic              DIN_VALID;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output bus_req, A, BYTE_SEL, MRD, CHARA, out_data, out_valid,
    input  bus_gnt, DIN, DIN_VALID, out_ready
  );

  modport slave (
    input  bus_req, A, BYTE_SEL, MRD, CHARA, out_data, out_valid,
    output bus_gnt, DIN, DIN_VALID, out_ready
  );
endinterface

// File: rtl/board_b_d_byte_ser.sv
// 16-to-8 serializer: loads a word, emits low byte then high byte over valid/ready.
module board_b_d_byte_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] word_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [7:0]  data_o
);

  logic [7:0] hi_byte_q, hi_byte_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       hi_q, hi_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_byte_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      hi_q      <= 1'b0;
    end else begin
      hi_byte_q <= hi_byte_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      hi_q      <= hi_d;
    end
  end

  // Output byte only advances on a completed handshake, so it holds under backpressure.
  always_comb begin
    hi_byte_d = hi_byte_q;
    data_d    = data_q;
    valid_d   = valid_q;
    hi_d      = hi_q;
    if (load_i) begin
      hi_byte_d = word_i[15:8];
      data_d    = word_i[7:0];
      valid_d   = 1'b1;
      hi_d      = 1'b0;
    end else if (valid_q && ready_i) begin
      if (!hi_q) begin
        data_d = hi_byte_q;
        hi_d   = 1'b1;
      end else begin
        valid_d = 1'b0;
        hi_d    = 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/board_b_d_readback.sv
// Reads a block of 16-bit words from CHARA space, one bus grant per word, and streams them as bytes.
module board_b_d_readback
  import video_bus_pkg::*;
#(
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned ADDR_W   = 20
) (
  input  logic              CLK_32M,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic              rd_error,
  board_b_d_readback_if.master bus
);

  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  rb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_err_d;
  logic              load_c;
  logic              hs_c;
  logic              rd_n_c;

  assign hs_c   = bus.out_valid & bus.out_ready;
  assign rd_n_c = (state_d == READ);

  // Bus outputs are registered from the next state so they assert/drop with the state change.
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      rd_error     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.bus_req  <= 1'b0;
      bus.MRD      <= 1'b0;
      bus.CHARA    <= 1'b0;
      bus.A        <= '0;
      bus.BYTE_SEL <= 2'b00;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      rd_error     <= rd_err_d;
      busy         <= (state_d != IDLE);
      done         <= (state_d == DONE);
      bus.bus_req  <= (state_d == REQ) || (state_d == READ);
      bus.MRD      <= rd_n_c;
      bus.CHARA    <= rd_n_c;
      bus.A        <= rd_n_c ? addr_d : '0;
      bus.BYTE_SEL <= rd_n_c ? BYTE_SEL_WORD : 2'b00;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    rd_err_d = rd_error;
    load_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_err_d = 1'b0;
          if (word_count == 16'd0) begin
            state_d = DONE;
          end else begin
            addr_d  = base_addr & ~ADDR_W'(1);
            rem_d   = word_count;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.bus_gnt) begin
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        // Losing the grant, even in the sample cycle, discards the read and retries the same word.
        if (!bus.bus_gnt) begin
          cnt_d   = '0;
          state_d = REQ;
        end else if (cnt_q == CNT_W'(READ_LAT - 1)) begin
          load_c  = 1'b1;
          cnt_d   = '0;
          state_d = SEND_LO;
          if (!bus.DIN_VALID) rd_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND_LO: begin
        if (hs_c) state_d = SEND_HI;
      end
      SEND_HI: begin
        if (hs_c) begin
          addr_d  = addr_q + ADDR_W'(2);
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? DONE : REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  board_b_d_byte_ser u_ser (
    .clk     (CLK_32M),
    .rst     (reset),
    .load_i  (load_c),
    .word_i  (bus.DIN),
    .ready_i (bus.out_ready),
    .valid_o (bus.out_valid),
    .data_o  (bus.out_data)
  );

endmodule

// File: tb/tb_board_b_d_readback.sv
// Directed bench for board_b_d_readback: board model returns DIN = A[15:0].
`timescale 1ns/1ps
module tb_board_b_d_readback;

  logic        CLK_32M = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done, rd_error;

  board_b_d_readback_if #(.ADDR_W(20)) bus ();

  board_b_d_readback #(.READ_LAT(2), .ADDR_W(20)) dut (
    .CLK_32M    (CLK_32M),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .rd_error   (rd_error),
    .bus        (bus)
  );

  always #5 CLK_32M = ~CLK_32M;

  logic        bad_en;
  logic [19:0] bad_addr;
  always_comb begin
    bus.DIN       = bus.A[15:0];
    bus.DIN_VALID = !(bad_en && bus.MRD && (bus.A == bad_addr));
  end

  int n_total = 0;
  int n_bad   = 0;
  int viol    = 0;
  logic [7:0]  rx_q [$];
  logic [19:0] rd_q [$];
  logic [7:0]  exp_b [$];
  logic [19:0] exp_a [$];
  logic        mrd_prev = 1'b0;
  logic        v_prev = 1'b0, r_prev = 1'b0;
  logic [7:0]  d_prev = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus/stream monitor: captures bytes and read addresses, flags protocol violations.
  always @(posedge CLK_32M) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) rx_q.push_back(bus.out_data);
      if (bus.MRD && !mrd_prev) rd_q.push_back(bus.A);
      if (bus.MRD && bus.BYTE_SEL != 2'b11) viol++;
      if (!bus.MRD && (bus.A != 20'h0 || bus.BYTE_SEL != 2'b00)) viol++;
      if (bus.MRD != bus.CHARA) viol++;
      if (v_prev && !r_prev && (!bus.out_valid || bus.out_data != d_prev)) viol++;
    end
    mrd_prev <= bus.MRD;
    v_prev   <= bus.out_valid;
    r_prev   <= bus.out_ready;
    d_prev   <= bus.out_data;
  end

  task automatic check_stream(input string tag);
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hdead, 32'(exp_b[i]));
    chk({tag, "_nreads"}, 32'(rd_q.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++)
      chk($sformatf("%s_a%0d", tag, i), (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hdead, 32'(exp_a[i]));
  endtask

  task automatic run_cmd(input logic [19:0] base, input logic [15:0] wc, output int dcyc);
    rx_q.delete();
    rd_q.delete();
    @(negedge CLK_32M);
    base_addr  = base;
    word_count = wc;
    start      = 1'b1;
    dcyc       = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge CLK_32M); #1;
      start = 1'b0;
      if (n == 1) chk("busy_on_accept", 32'(busy), 32'd1);
      if (done) begin
        dcyc = n;
        break;
      end
    end
    if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
    @(posedge CLK_32M); #1;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  int dc;
  int seen;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    bus.bus_gnt = 1'b1; bus.out_ready = 1'b1;
    bad_en = 1'b0; bad_addr = '0;

    repeat (3) @(negedge CLK_32M);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus_req", 32'(bus.bus_req), 32'd0);
    chk("rst_mrd", 32'(bus.MRD), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rd_error", 32'(rd_error), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge CLK_32M);

    // Basic three-word read at 0x00100.
    run_cmd(20'h00100, 16'd3, dc);
    chk("basic_done_cycle", 32'(dc), 32'd16);
    chk("basic_rd_error", 32'(rd_error), 32'd0);
    exp_b = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h04, 8'h01};
    exp_a = '{20'h00100, 20'h00102, 20'h00104};
    check_stream("basic");

    // Zero-length command.
    run_cmd(20'h00100, 16'd0, dc);
    chk("zero_done_cycle", 32'(dc), 32'd1);
    exp_b = {};
    exp_a = {};
    check_stream("zero");

    // Grant dropped in the sample cycle of the word at 0x00102.
    fork
      run_cmd(20'h00101, 16'd3, dc);
      begin
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
          @(posedge CLK_32M); #1;
          if (bus.MRD && bus.A == 20'h00102) seen = 1;
        end
        if (seen == 0) chk("gnt_wait_timeout", 32'd0, 32'd1);
        @(posedge CLK_32M); #1;
        bus.bus_gnt = 1'b0;
        @(posedge CLK_32M); #1;
        chk("gnt_drop_mrd", 32'(bus.MRD), 32'd0);
        chk("gnt_drop_req", 32'(bus.bus_req), 32'd1);
        bus.bus_gnt = 1'b1;
      end
    join
    chk("gnt_done_cycle", 32'(dc), 32'd19);
    exp_b = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h04, 8'h01};
    exp_a = '{20'h00100, 20'h00102, 20'h00102, 20'h00104};
    check_stream("gnt");

    // Backpressure on the high byte of the first word.
    fork
      run_cmd(20'h00100, 16'd2, dc);
      begin
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
          @(posedge CLK_32M); #1;
          if (rx_q.size() == 1) seen = 1;
        end
        if (seen == 0) chk("bp_wait_timeout", 32'd0, 32'd1);
        bus.out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
          @(posedge CLK_32M); #1;
          if (!bus.out_valid || bus.out_data != 8'h01 || bus.MRD) seen++;
        end
        chk("bp_hold_stable", 32'(seen), 32'd0);
        bus.out_ready = 1'b1;
      end
    join
    chk("bp_done_cycle", 32'(dc), 32'd21);
    exp_b = '{8'h00, 8'h01, 8'h02, 8'h01};
    exp_a = '{20'h00100, 20'h00102};
    check_stream("bp");

    // Address wrap with an invalid read on the second word.
    bad_en = 1'b1; bad_addr = 20'h00000;
    run_cmd(20'hFFFFE, 16'd2, dc);
    chk("wrap_done_cycle", 32'(dc), 32'd11);
    chk("wrap_rd_error", 32'(rd_error), 32'd1);
    exp_b = '{8'hFE, 8'hFF, 8'h00, 8'h00};
    exp_a = '{20'hFFFFE, 20'h00000};
    check_stream("wrap");
    repeat (3) @(posedge CLK_32M); #1;
    chk("rd_error_sticky", 32'(rd_error), 32'd1);
    bad_en = 1'b0;
    run_cmd(20'h00010, 16'd1, dc);
    chk("clr_rd_error", 32'(rd_error), 32'd0);
    exp_b = '{8'h10, 8'h00};
    exp_a = '{20'h00010};
    check_stream("clr");

    // Reset asserted while MRD is high.
    rx_q.delete(); rd_q.delete();
    @(negedge CLK_32M);
    base_addr = 20'h00100; word_count = 16'd3; start = 1'b1;
    @(negedge CLK_32M);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(posedge CLK_32M); #1;
      if (bus.MRD) seen = 1;
    end
    if (seen == 0) chk("rst_wait_timeout", 32'd0, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mrd", 32'(bus.MRD), 32'd0);
    chk("midrst_chara", 32'(bus.CHARA), 32'd0);
    chk("midrst_bus_req", 32'(bus.bus_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge CLK_32M);
    reset = 1'b0;
    rx_q.delete(); rd_q.delete();
    repeat (12) @(posedge CLK_32M); #1;
    chk("midrst_no_bytes", 32'(rx_q.size()), 32'd0);
    chk("midrst_no_reads", 32'(rd_q.size()), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
